eth_tx_framer: RTL



---
 rtl/eth_pkg.sv | 21 ++
 rtl/eth_tx_framer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit framer: frame states and the
// fixed preamble/SFD/FCS constants.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        PAD  = 3'd4,
        FCS  = 3'd5,
        IFG  = 3'd6
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam int          FCS_LEN       = 4;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

endpackage

// File: rtl/eth_tx_framer.sv
// Transmit framer: wraps a payload stream in preamble/SFD, pads to the minimum
// length, appends the FCS read from the downstream CRC stage and enforces the IFG.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_LEN    = 60,
    parameter int IFG_CYCLES = 12,
    parameter int CNT_W      = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] crc_d,
    output logic       crc_calc,
    output logic       crc_d_valid,
    output logic       crc_init,
    input  logic [7:0] crc_byte,
    output logic       busy
);

    localparam int SUB_W = 8;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   byte_cnt_r;
    logic [CNT_W-1:0]   byte_cnt_s;
    logic [CNT_W-1:0]   byte_inc_s;
    logic [CNT_W:0]     cnt_plus1_s;
    logic [SUB_W-1:0]   sub_cnt_r;
    logic [SUB_W-1:0]   sub_cnt_s;
    logic               acc_s;

    assign acc_s       = out_valid & out_ready;
    assign cnt_plus1_s = {1'b0, byte_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    // Saturating byte count; long frames are passed through untruncated.
    assign byte_inc_s  = (byte_cnt_r == {CNT_W{1'b1}}) ? byte_cnt_r : cnt_plus1_s[CNT_W-1:0];

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            byte_cnt_r <= {CNT_W{1'b0}};
            sub_cnt_r  <= {SUB_W{1'b0}};
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            sub_cnt_r  <= sub_cnt_s;
        end
    end

    // Byte-lane and CRC-control outputs decoded from the current state
    always_comb begin
        out_data  = 8'h00;
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        crc_calc  = 1'b0;
        crc_init  = 1'b0;
        case (state_r)
            IDLE: begin
                crc_init = 1'b1;
            end
            PRE: begin
                out_data  = PREAMBLE_BYTE;
                out_valid = 1'b1;
            end
            SFD: begin
                out_data  = SFD_BYTE;
                out_valid = 1'b1;
            end
            DATA: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                crc_calc  = 1'b1;
            end
            PAD: begin
                out_data  = 8'h00;
                out_valid = 1'b1;
                crc_calc  = 1'b1;
            end
            FCS: begin
                out_data  = crc_byte;
                out_valid = 1'b1;
                if (sub_cnt_r == SUB_W'(FCS_LEN - 1)) begin
                    out_last = 1'b1;
                end else begin
                    out_last = 1'b0;
                end
            end
            IFG: begin
                out_valid = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign crc_d       = out_data;
    assign crc_d_valid = acc_s & ((state_r == DATA) | (state_r == PAD) | (state_r == FCS));
    assign busy        = (state_r != IDLE);

    // Next-state and counter update; every byte state advances only on an accept
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        sub_cnt_s  = sub_cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s   = PRE;
                    sub_cnt_s = {SUB_W{1'b0}};
                end else begin
                    state_s   = IDLE;
                end
            end
            PRE: begin
                if (acc_s) begin
                    if (sub_cnt_r == SUB_W'(PREAMBLE_LEN - 1)) begin
                        state_s   = SFD;
                        sub_cnt_s = {SUB_W{1'b0}};
                    end else begin
                        sub_cnt_s = sub_cnt_r + {{(SUB_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = PRE;
                end
            end
            SFD: begin
                if (acc_s) begin
                    state_s    = DATA;
                    byte_cnt_s = {CNT_W{1'b0}};
                end else begin
                    state_s = SFD;
                end
            end
            DATA: begin
                if (acc_s) begin
                    byte_cnt_s = byte_inc_s;
                    if (in_last) begin
                        if (cnt_plus1_s < (CNT_W+1)'(MIN_LEN)) begin
                            state_s = PAD;
                        end else begin
                            state_s   = FCS;
                            sub_cnt_s = {SUB_W{1'b0}};
                        end
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PAD: begin
                if (acc_s) begin
                    byte_cnt_s = byte_inc_s;
                    if (cnt_plus1_s == (CNT_W+1)'(MIN_LEN)) begin
                        state_s   = FCS;
                        sub_cnt_s = {SUB_W{1'b0}};
                    end else begin
                        state_s = PAD;
                    end
                end else begin
                    state_s = PAD;
                end
            end
            FCS: begin
                if (acc_s) begin
                    if (sub_cnt_r == SUB_W'(FCS_LEN - 1)) begin
                        state_s   = IFG;
                        sub_cnt_s = {SUB_W{1'b0}};
                    end else begin
                        sub_cnt_s = sub_cnt_r + {{(SUB_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = FCS;
                end
            end
            IFG: begin
                // The mandatory IDLE cycle that follows supplies the last gap cycle
                if (sub_cnt_r >= SUB_W'(IFG_CYCLES - 2)) begin
                    state_s = IDLE;
                end else begin
                    sub_cnt_s = sub_cnt_r + {{(SUB_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule
